i2c_master: RTL
===============

// Module: i2c_master
// PURPOSE
//  Single-byte I2C initiator that issues write/read transactions to the slave fronting i2c_mem.
//  Frame: START, {addr[6:0], op}, slave ACK, 8 data bits, ACK/NACK, STOP.
//  Open-drain SDA; the master drives SCL (no clock stretching, no multi-master arbitration).
// PARAMETERS
//  SYS_FREQ  40_000_000  system clock frequency, Hz
//  I2C_FREQ  100_000     SCL frequency, Hz; CLK_DIV = SYS_FREQ/I2C_FREQ, must be a multiple of 4 and >= 8
// PORTS
//  clk      in     1  system clock, rising edge
//  rst      in     1  asynchronous, active-low reset
//  newd     in     1  start request; sampled only while busy==0
//  op       in     1  0 = write, 1 = read; captured with newd
//  addr     in     7  memory/slave address; captured with newd
//  din      in     8  write data; captured with newd
//  dout     out    8  read data; valid when done pulses after a read
//  busy     out    1  high from the cycle after newd accept until done
//  done     out    1  one-cycle pulse at end of STOP, on success or error
//  ack_err  out    1  slave NACK seen; held until the next accepted newd
//  scl      out    1  I2C clock, push-pull, idles 1
//  sda      inout  1  I2C data; master drives 0 or 'z only, never 1
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, scl=1, sda released, busy=0, done=0, ack_err=0, dout=0,
//    all counters 0. Reset mid-frame aborts at once: bus released, no done pulse.
//  - Bit timing: a quarter tick every Q=CLK_DIV/4 clk. Each bit has 4 phases p0..p3:
//    p0 scl=0, SDA updated; p1 scl=0; p2 scl=1, SDA sampled; p3 scl=1.
//    SDA changes only while scl=0, except in START and STOP.
//  - Accept: in IDLE with newd=1, latch op/addr/din, clear ack_err, set busy next cycle.
//    newd while busy is ignored.
//  - FSM: IDLE -> START -> ADDR(8 bits, MSB first, last bit = op) -> ADDR_ACK
//    -> WR_DATA(8) -> DATA_ACK -> STOP       when op=0
//    -> RD_DATA(8) -> MST_NACK -> STOP       when op=1
//    -> IDLE
//  - START: sda released for p0-p1, then driven 0 in p2-p3 while scl=1.
//  - STOP: sda 0 with scl low in p0-p1, scl=1 in p2, sda released in p3.
//  - ADDR_ACK / DATA_ACK: sda released; sample in p2. Sample 1 = NACK: set ack_err and go
//    directly to STOP. RD_DATA and WR_DATA are skipped after an address NACK.
//  - RD_DATA: sda released; shift the bit in at p2, MSB first. dout updates at the end of MST_NACK.
//  - MST_NACK: master releases sda (NACK) to end the read.
//  - done pulses one clk after STOP p3 ends; busy falls in the same cycle; IDLE is re-entered.
//  - Latency: successful frame = 20 bit periods = 20*CLK_DIV clk from accept to done.
//    A treated 'z' or 'x' sampled on sda counts as 1, i.e. the bus is pulled up.
//  - Bit counter 3 bits, counts 7 down to 0; the quarter counter wraps at Q-1.
// STRUCTURE
//  - i2c_pkg: typedef enum logic [3:0] i2c_state_t {IDLE, START, ADDR, ADDR_ACK, WR_DATA,
//    DATA_ACK, RD_DATA, MST_NACK, STOP}; localparams OP_WR=1'b0, OP_RD=1'b1.
//    The package is shared with the slave-side controller.
//  - Sub-module i2c_tick_gen: divides clk and outputs a quarter-tick pulse plus a 2-bit phase.
//    Its counter is held at 0 while IDLE.
//  - Top level: FSM, shift registers, open-drain assign sda = sda_oe ? 1'b0 : 1'bz.
// TESTING (bench: pullup on sda, behavioural slave wrapping i2c_mem, CLK_DIV=400)
//  - Reset: rst=0 mid-frame at bit 5 of ADDR -> scl=1, sda='z', busy=0 and no done
//    within 1 clk of rst falling.
//  - Write: op=0, addr=7'h12, din=8'hA5 -> bus bits 0x24 then 0xA5; i2c_mem[0x12]==8'hA5;
//    done at exactly 8000 clk; ack_err=0.
//  - Read: preload mem[0x12]=8'h3C; op=1, addr=7'h12 -> address byte 0x25, dout==8'h3C at done,
//    master NACK observed on the 9th data-phase clock.
//  - Address NACK: slave model disabled; op=0 -> ack_err=1, no data byte on the bus,
//    STOP follows the ACK slot, done after 11*CLK_DIV clk.
//  - Busy guard: pulse newd with a new addr during a frame -> ignored; only one frame
//    on the bus, latched addr unchanged.
//  - Protocol checker: sda never changes while scl=1 except at START (1->0) and STOP (0->1);
//    scl period = 400 clk +/-0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller states and transfer direction codes.
// Used by both the master and the slave-side controller.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        DATA_ACK,
        RD_DATA,
        MST_NACK,
        STOP
    } i2c_state_t;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: one tick every Q clocks plus the 2-bit phase index.
// Held at zero while the controller is idle so every frame starts aligned.
module i2c_tick_gen #(
    parameter int Q = 100
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    output logic       tick_o,
    output logic [1:0] phase_o
);

    localparam int CW = (Q > 1) ? $clog2(Q) : 1;

    logic [CW-1:0] cnt_q;
    logic [1:0]    phase_q;

    assign tick_o  = run_i && (cnt_q == CW'(Q - 1));
    assign phase_o = phase_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (!run_i) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else if (tick_o) begin
            cnt_q   <= '0;
            phase_q <= phase_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address+op, ACK, one data byte, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain and only ever pulled low.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int SYS_FREQ = 40_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       op,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int CLK_DIV = SYS_FREQ / I2C_FREQ;
    localparam int Q       = CLK_DIV / 4;

    i2c_state_t state_q;
    logic [1:0] phase;
    logic       tick;
    logic [2:0] bit_q;
    logic [7:0] tx_q, rx_q, dout_q, din_q;
    logic [6:0] addr_q;
    logic       op_q, busy_q, done_q, ack_err_q;
    logic       scl_q, oe_q, sda_s;

    i2c_tick_gen #(.Q(Q)) u_tick (
        .clk_i  (clk),
        .rst_ni (rst),
        .run_i  (state_q != IDLE),
        .tick_o (tick),
        .phase_o(phase)
    );

    // A floating or unknown line reads as the pulled-up level.
    assign sda_s = (sda !== 1'b0);

    // Bus drive {scl, sda_oe} for a given state, phase and transmit bit.
    function automatic logic [1:0] drv(input i2c_state_t s,
                                       input logic [1:0] p,
                                       input logic b);
        unique case (s)
            IDLE:          drv = 2'b10;
            START:         drv = {1'b1, p[1]};
            STOP:          drv = {p[1], p != 2'd3};
            ADDR, WR_DATA: drv = {p[1], ~b};
            default:       drv = {p[1], 1'b0};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            dout_q    <= '0;
            din_q     <= '0;
            addr_q    <= '0;
            op_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (newd) begin
                    op_q      <= op;
                    addr_q    <= addr;
                    din_q     <= din;
                    ack_err_q <= 1'b0;
                    busy_q    <= 1'b1;
                    bit_q     <= 3'd7;
                    state_q   <= START;
                    {scl_q, oe_q} <= drv(START, 2'd0, 1'b0);
                end
            end else if (tick) begin
                if (phase == 2'd2) begin
                    if (state_q inside {ADDR_ACK, DATA_ACK})
                        ack_err_q <= ack_err_q | sda_s;
                    if (state_q == RD_DATA)
                        rx_q <= {rx_q[6:0], sda_s};
                end
                if (phase != 2'd3) begin
                    {scl_q, oe_q} <= drv(state_q, phase + 2'd1, tx_q[7]);
                end else begin
                    bit_q <= bit_q - 3'd1;
                    unique case (state_q)
                        START: begin
                            state_q <= ADDR;
                            bit_q   <= 3'd7;
                            tx_q    <= {addr_q, op_q};
                            {scl_q, oe_q} <= drv(ADDR, 2'd0, addr_q[6]);
                        end
                        ADDR, WR_DATA: begin
                            tx_q <= {tx_q[6:0], 1'b0};
                            if (bit_q == 3'd0) begin
                                state_q <= (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                                {scl_q, oe_q} <= drv(ADDR_ACK, 2'd0, 1'b0);
                            end else begin
                                {scl_q, oe_q} <= drv(state_q, 2'd0, tx_q[6]);
                            end
                        end
                        ADDR_ACK: begin
                            bit_q <= 3'd7;
                            if (ack_err_q) begin
                                state_q <= STOP;
                                {scl_q, oe_q} <= drv(STOP, 2'd0, 1'b0);
                            end else if (op_q == OP_WR) begin
                                state_q <= WR_DATA;
                                tx_q    <= din_q;
                                {scl_q, oe_q} <= drv(WR_DATA, 2'd0, din_q[7]);
                            end else begin
                                state_q <= RD_DATA;
                                {scl_q, oe_q} <= drv(RD_DATA, 2'd0, 1'b0);
                            end
                        end
                        RD_DATA: begin
                            if (bit_q == 3'd0) begin
                                state_q <= MST_NACK;
                                {scl_q, oe_q} <= drv(MST_NACK, 2'd0, 1'b0);
                            end else begin
                                {scl_q, oe_q} <= drv(RD_DATA, 2'd0, 1'b0);
                            end
                        end
                        DATA_ACK, MST_NACK: begin
                            if (state_q == MST_NACK)
                                dout_q <= rx_q;
                            state_q <= STOP;
                            {scl_q, oe_q} <= drv(STOP, 2'd0, 1'b0);
                        end
                        default: begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            {scl_q, oe_q} <= drv(IDLE, 2'd0, 1'b0);
                        end
                    endcase
                end
            end
        end
    end

    assign sda     = oe_q ? 1'b0 : 1'bz;
    assign scl     = scl_q;
    assign dout    = dout_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule
